uart_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter and sequencer that shares a single `uart_transmitter` between `NumRequesters` byte-stream producers on the iCE40 uncore. A granted requester owns the transmitter until it delivers a byte flagged `last` or goes silent past a timeout. The block presents one byte at a time to the transmitter and waits for each byte to finish before accepting the next, so bytes from different packets never interleave.

---
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter that shares one UART transmitter between several byte-stream
// producers; a grant lasts until the owner's last byte or an idle timeout.
module uart_tx_arbiter #(
  parameter int unsigned NumRequesters = 4,
  parameter int unsigned TimeoutCycles = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NumRequesters-1:0]   req_valid,
  input  logic [8*NumRequesters-1:0] req_byte,
  input  logic [NumRequesters-1:0]   req_last,
  output logic [NumRequesters-1:0]   req_ready_out,
  output logic [NumRequesters-1:0]   grant_out,
  output logic                       timeout_out,
  output logic [7:0]                 tx_byte_out,
  output logic                       tx_byte_valid_out,
  input  logic                       tx_byte_done
);

  localparam int unsigned IdxW = $clog2(NumRequesters);
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumRequesters - 1);
  localparam logic [CntW-1:0] CntLimit = CntW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    StateIdle,
    StateGranted,
    StateSend,
    StateSettle,
    StateWaitDone
  } state_e;

  state_e                   state_q, state_d;
  logic [NumRequesters-1:0] grant_q, grant_d;
  logic [IdxW-1:0]          owner_q, owner_d;
  logic [IdxW-1:0]          last_grant_q, last_grant_d;
  logic [CntW-1:0]          idle_cnt_q, idle_cnt_d;
  logic                     pkt_last_q, pkt_last_d;
  logic                     timeout_q, timeout_d;
  logic [7:0]               tx_byte_q, tx_byte_d;
  logic                     tx_valid_q, tx_valid_d;
  logic [IdxW-1:0]          pick_idx;

  // Scanning distances from farthest to nearest lets the nearest valid requester win.
  function automatic logic [IdxW-1:0] rr_pick(input logic [IdxW-1:0]          last,
                                              input logic [NumRequesters-1:0] valid);
    logic [IdxW-1:0] pick;
    logic [IdxW:0]   cand;
    pick = last;
    for (int unsigned k = NumRequesters; k > 0; k--) begin
      cand = {1'b0, last} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(NumRequesters)) begin
        cand = cand - (IdxW+1)'(NumRequesters);
      end
      if (valid[cand[IdxW-1:0]]) begin
        pick = cand[IdxW-1:0];
      end
    end
    return pick;
  endfunction

  assign pick_idx = rr_pick(last_grant_q, req_valid);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    idle_cnt_d   = idle_cnt_q;
    pkt_last_d   = pkt_last_q;
    timeout_d    = 1'b0;
    tx_byte_d    = tx_byte_q;
    tx_valid_d   = tx_valid_q;

    unique case (state_q)
      StateIdle: begin
        grant_d    = '0;
        idle_cnt_d = '0;
        if (|req_valid) begin
          owner_d           = pick_idx;
          grant_d[pick_idx] = 1'b1;
          state_d           = StateGranted;
        end
      end

      StateGranted: begin
        if (req_valid[owner_q]) begin
          tx_byte_d  = req_byte[{owner_q, 3'b000} +: 8];
          pkt_last_d = req_last[owner_q];
          tx_valid_d = 1'b1;
          idle_cnt_d = '0;
          state_d    = StateSend;
        end else if (idle_cnt_q >= CntLimit) begin
          timeout_d    = 1'b1;
          last_grant_d = owner_q;
          grant_d      = '0;
          idle_cnt_d   = '0;
          state_d      = StateIdle;
        end else if (idle_cnt_q != {CntW{1'b1}}) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      StateSend: begin
        if (tx_byte_done) begin
          tx_valid_d = 1'b0;
          state_d    = StateSettle;
        end
      end

      // Gives the transmitter a cycle to drop tx_byte_done before we look at it again.
      StateSettle: begin
        state_d = StateWaitDone;
      end

      StateWaitDone: begin
        if (tx_byte_done) begin
          if (pkt_last_q) begin
            last_grant_d = owner_q;
            grant_d      = '0;
            state_d      = StateIdle;
          end else begin
            state_d = StateGranted;
          end
        end
      end

      default: begin
        state_d = StateIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StateIdle;
      grant_q      <= '0;
      owner_q      <= '0;
      last_grant_q <= LastIdx;
      idle_cnt_q   <= '0;
      pkt_last_q   <= 1'b0;
      timeout_q    <= 1'b0;
      tx_byte_q    <= 8'hff;
      tx_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      idle_cnt_q   <= idle_cnt_d;
      pkt_last_q   <= pkt_last_d;
      timeout_q    <= timeout_d;
      tx_byte_q    <= tx_byte_d;
      tx_valid_q   <= tx_valid_d;
    end
  end

  assign req_ready_out     = (state_q == StateGranted) ? grant_q : '0;
  assign grant_out         = grant_q;
  assign timeout_out       = timeout_q;
  assign tx_byte_out       = tx_byte_q;
  assign tx_byte_valid_out = tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed packets feed an expected-byte queue that a
// monitor drains as the transmitter model accepts bytes.
module tb_uart_tx_arbiter;

  localparam int unsigned N = 4;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] b;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_byte = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready_out;
  logic [N-1:0]   grant_out;
  logic           timeout_out;
  logic [7:0]     tx_byte_out;
  logic           tx_byte_valid_out;
  logic           tx_byte_done = 1'b1;

  logic [N-1:0]   req_valid1 = '0;
  logic [N-1:0]   req_ready1;
  logic [N-1:0]   grant1;
  logic           timeout1;
  logic [7:0]     tx_byte1;
  logic           tx_valid1;

  int   checks = 0;
  int   fails = 0;
  int   tcount = 0;
  int   busy_len = 2;
  int   busy = 0;
  bit   took = 1'b0;
  bit   popq [N];
  logic [8:0] rq [N][$];
  exp_t exp_q [$];
  logic       prev_valid = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NumRequesters(N), .TimeoutCycles(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_byte          (req_byte),
    .req_last          (req_last),
    .req_ready_out     (req_ready_out),
    .grant_out         (grant_out),
    .timeout_out       (timeout_out),
    .tx_byte_out       (tx_byte_out),
    .tx_byte_valid_out (tx_byte_valid_out),
    .tx_byte_done      (tx_byte_done)
  );

  uart_tx_arbiter #(.NumRequesters(N), .TimeoutCycles(1)) dut1 (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid1),
    .req_byte          (32'h7777_7777),
    .req_last          (4'b0000),
    .req_ready_out     (req_ready1),
    .grant_out         (grant1),
    .timeout_out       (timeout1),
    .tx_byte_out       (tx_byte1),
    .tx_byte_valid_out (tx_valid1),
    .tx_byte_done      (1'b1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic send(input int r, input logic last, input logic [7:0] b);
    rq[r].push_back({last, b});
  endtask

  task automatic expect_byte(input logic [3:0] g, input logic [7:0] b);
    exp_q.push_back({g, b});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || grant_out != '0 || rq[0].size() != 0 || rq[1].size() != 0 ||
            rq[2].size() != 0 || rq[3].size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_sb_empty"}, exp_q.size(), 0);
    check({name, "_idle_grant"}, grant_out, 0);
  endtask

  // Requester drivers: present queue head, pop after the edge that took it.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (popq[i]) begin
        void'(rq[i].pop_front());
        popq[i] = 1'b0;
      end
      if (rq[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_byte[8*i +: 8]   = rq[i][0][7:0];
        req_last[i]          = rq[i][0][8];
        if (!rst && req_ready_out[i]) popq[i] = 1'b1;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  end

  // Transmitter model: takes a byte when valid and done, then stays busy busy_len cycles.
  always @(negedge clk) begin
    if (rst) begin
      tx_byte_done = 1'b1;
      busy         = 0;
      took         = 1'b0;
    end else begin
      if (took) begin
        took = 1'b0;
        if (busy_len > 0) begin
          tx_byte_done = 1'b0;
          busy         = busy_len;
        end
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) tx_byte_done = 1'b1;
      end
      if (!took && busy == 0 && tx_byte_valid_out && tx_byte_done) took = 1'b1;
    end
  end

  // Scoreboard monitor plus cycle invariants.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (tx_byte_valid_out && tx_byte_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_tx_byte: got 0x%02h grant %b, required no byte",
                   tx_byte_out, grant_out);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", tx_byte_out, e.b);
          check("tx_grant", grant_out, e.g);
        end
      end
      check("ready_subset_of_grant", req_ready_out & ~grant_out, 0);
      if (tx_byte_valid_out || !tx_byte_done) check("no_ready_while_busy", req_ready_out, 0);
      if (prev_valid && tx_byte_valid_out) check("tx_byte_stable", tx_byte_out, prev_byte);
      if (timeout_out) tcount++;
    end
    prev_valid = tx_byte_valid_out;
    prev_byte  = tx_byte_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int t0;

    repeat (3) tick();
    check("reset_grant", grant_out, 0);
    check("reset_ready", req_ready_out, 0);
    check("reset_timeout", timeout_out, 0);
    check("reset_tx_byte", tx_byte_out, 8'hff);
    check("reset_tx_valid", tx_byte_valid_out, 0);
    rst = 1'b0;

    // Round robin: all four hold valid with two 1-byte packets each.
    for (int i = 0; i < N; i++) expect_byte(4'(1 << i), 8'(8'h10 + i));
    for (int i = 0; i < N; i++) expect_byte(4'(1 << i), 8'(8'h20 + i));
    for (int i = 0; i < N; i++) begin
      send(i, 1'b1, 8'(8'h10 + i));
      send(i, 1'b1, 8'(8'h20 + i));
    end
    wait_drain("round_robin", 400);

    // Single requester 2, three-byte packet.
    expect_byte(4'b0100, 8'h41);
    expect_byte(4'b0100, 8'h42);
    expect_byte(4'b0100, 8'h43);
    send(2, 1'b0, 8'h41);
    send(2, 1'b0, 8'h42);
    send(2, 1'b1, 8'h43);
    wait_drain("single", 200);

    // last_grant is now 2, so requester 3 outranks requester 1.
    expect_byte(4'b1000, 8'h53);
    expect_byte(4'b0010, 8'h51);
    send(1, 1'b1, 8'h51);
    send(3, 1'b1, 8'h53);
    wait_drain("last_grant", 200);

    // Atomicity: requester 0 arrives mid-packet of requester 1.
    for (int i = 0; i < 4; i++) begin
      expect_byte(4'b0010, 8'(8'h61 + i));
      send(1, (i == 3), 8'(8'h61 + i));
    end
    expect_byte(4'b0001, 8'h0a);
    n = 0;
    while (exp_q.size() > 3 && n < 100) begin
      tick();
      n++;
    end
    check("atomic_midway_owner", grant_out, 4'b0010);
    send(0, 1'b1, 8'h0a);
    wait_drain("atomic", 200);

    // Timeout: requester 3 stalls after one non-last byte.
    expect_byte(4'b1000, 8'h33);
    expect_byte(4'b0001, 8'h30);
    send(3, 1'b0, 8'h33);
    n = 0;
    while (!(grant_out == 4'b1000 && req_ready_out[3] && rq[3].size() == 0) && n < 100) begin
      tick();
      n++;
    end
    check("timeout_regranted", req_ready_out, 4'b1000);
    send(0, 1'b1, 8'h30);
    n = 0;
    while (!timeout_out && n < 20) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, 8);
    check("timeout_grant_cleared", grant_out, 0);
    tick();
    check("timeout_pulse_width", timeout_out, 0);
    check("timeout_next_grant", grant_out, 4'b0001);
    wait_drain("timeout", 200);

    // Slow transmitter: 100 busy cycles per byte.
    busy_len = 100;
    expect_byte(4'b0010, 8'h71);
    expect_byte(4'b0010, 8'h72);
    send(1, 1'b0, 8'h71);
    send(1, 1'b1, 8'h72);
    t0 = $time;
    wait_drain("slow_tx", 600);
    check("slow_tx_duration", (($time - t0) / 10) >= 200, 1);

    // Reset during WaitDone of a 3-byte packet from requester 2.
    busy_len = 5;
    expect_byte(4'b0100, 8'ha0);
    expect_byte(4'b0001, 8'h0f);
    expect_byte(4'b0100, 8'ha1);
    expect_byte(4'b0100, 8'ha2);
    expect_byte(4'b1000, 8'h3f);
    send(2, 1'b0, 8'ha0);
    send(2, 1'b0, 8'ha1);
    send(2, 1'b1, 8'ha2);
    send(0, 1'b1, 8'h0f);
    send(3, 1'b1, 8'h3f);
    n = 0;
    while (!(exp_q.size() == 4 && grant_out == 4'b0100 && !tx_byte_done && !tx_byte_valid_out)
           && n < 100) begin
      tick();
      n++;
    end
    tick();
    check("pre_reset_owner", grant_out, 4'b0100);
    rst = 1'b1;
    tick();
    check("midrst_grant", grant_out, 0);
    check("midrst_ready", req_ready_out, 0);
    check("midrst_timeout", timeout_out, 0);
    check("midrst_tx_byte", tx_byte_out, 8'hff);
    check("midrst_tx_valid", tx_byte_valid_out, 0);
    rst = 1'b0;
    tick();
    check("restart_priority", grant_out, 4'b0001);
    wait_drain("reset_restart", 300);
    busy_len = 2;

    // TimeoutCycles=1: the owner drops valid as its grant appears.
    req_valid1 = 4'b0010;
    tick();
    check("t1_grant", grant1, 4'b0010);
    check("t1_ready", req_ready1, 4'b0010);
    req_valid1 = 4'b0000;
    tick();
    check("t1_timeout", timeout1, 1);
    check("t1_grant_cleared", grant1, 0);
    check("t1_tx_valid", tx_valid1, 0);
    tick();
    check("t1_timeout_pulse", timeout1, 0);

    check("timeout_pulse_count", tcount, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
